// File: rtl/spi_reg_bank_if.sv
// spi_reg_bank_if: synchronized SPI lines, block enable and register-bank outputs.
// slave modport faces the register bank; master modport faces the driver/observer.
interface spi_reg_bank_if #(
    parameter int unsigned NUM_REGS  = 4,
    parameter int unsigned REG_WIDTH = 8
);
    logic                          ena;
    logic                          spi_cs_n;
    logic                          spi_sclk;
    logic                          spi_mosi;
    logic                          spi_miso;
    logic [NUM_REGS*REG_WIDTH-1:0] regs;
    logic                          wr_strobe;
    logic [6:0]                    wr_addr;

    modport slave (
        input  ena, spi_cs_n, spi_sclk, spi_mosi,
        output spi_miso, regs, wr_strobe, wr_addr
    );

    modport master (
        output ena, spi_cs_n, spi_sclk, spi_mosi,
        input  spi_miso, regs, wr_strobe, wr_addr
    );
endinterface

// File: rtl/spi_reg_bank.sv
// spi_reg_bank: SPI mode-0 slave decoding 16-bit frames {RW, addr[6:0], data[7:0]}
// into a bank of configuration registers for the ALU.
// Optional feature macro: SPI_READBACK_EN (read frames shift register data out on MISO).
module spi_reg_bank #(
    parameter int unsigned NUM_REGS  = 4,
    parameter int unsigned REG_WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    spi_reg_bank_if.slave      bus
);

    localparam int unsigned CNT_W   = 5;
    localparam logic [7:0]  NREGS_C = 8'(NUM_REGS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMD  = 2'd1,
        S_DATA = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nx;
    logic                 r_sclk_q;
    logic                 r_cs_q;
    logic [CNT_W-1:0]     r_cnt;
    logic [6:0]           r_sr;
    logic                 r_rw;
    logic [6:0]           r_addr;
    logic [REG_WIDTH-1:0] r_regs [NUM_REGS];
    logic                 r_wr_strobe;
    logic [6:0]           r_wr_addr;

    logic w_rise, w_fall, w_cs_fall, w_cs_rise, w_addr_ok;
    logic w_clr, w_shift_in, w_latch_cmd, w_commit;

    assign w_rise    =  bus.spi_sclk & ~r_sclk_q;
    assign w_fall    = ~bus.spi_sclk &  r_sclk_q;
    assign w_cs_fall = ~bus.spi_cs_n &  r_cs_q;
    assign w_cs_rise =  bus.spi_cs_n & ~r_cs_q;
    assign w_addr_ok = ({1'b0, r_addr} < NREGS_C);

    // Previous-value tracking of sclk and cs_n, independent of ena
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sclk_q <= 1'b0;
            r_cs_q   <= 1'b1;
        end else begin
            r_sclk_q <= bus.spi_sclk;
            r_cs_q   <= bus.spi_cs_n;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nx;
    end

    // Next-state logic; disable or cs release aborts from any state
    always_comb begin
        w_state_nx = r_state;
        if (!bus.ena || w_cs_rise) begin
            w_state_nx = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_cs_fall) w_state_nx = S_CMD;
                S_CMD:   if (w_fall && r_cnt == CNT_W'(8)) w_state_nx = S_DATA;
                S_DATA:  if (w_rise && r_cnt == CNT_W'(15)) w_state_nx = S_DONE;
                S_DONE:  w_state_nx = S_DONE;
                default: w_state_nx = S_IDLE;
            endcase
        end
    end

`ifdef SPI_READBACK_EN
    logic                 w_load_out, w_shift_out;
    logic [REG_WIDTH-1:0] r_out;
    logic [REG_WIDTH-1:0] w_out_nx;
    logic [REG_WIDTH-1:0] w_rd_data;
    logic                 r_miso;
`endif

    // Datapath control decode from current state and detected edges
    always_comb begin
        w_clr       = 1'b0;
        w_shift_in  = 1'b0;
        w_latch_cmd = 1'b0;
        w_commit    = 1'b0;
`ifdef SPI_READBACK_EN
        w_load_out  = 1'b0;
        w_shift_out = 1'b0;
`endif
        if (bus.ena && !w_cs_rise) begin
            case (r_state)
                S_IDLE: w_clr = w_cs_fall;
                S_CMD: begin
                    w_shift_in  = w_rise && (r_cnt < CNT_W'(8));
                    w_latch_cmd = w_rise && (r_cnt == CNT_W'(7));
`ifdef SPI_READBACK_EN
                    w_load_out  = w_fall && (r_cnt == CNT_W'(8));
`endif
                end
                S_DATA: begin
                    w_shift_in  = w_rise;
                    w_commit    = w_rise && (r_cnt == CNT_W'(15)) && r_rw && w_addr_ok;
`ifdef SPI_READBACK_EN
                    w_shift_out = w_fall;
`endif
                end
                default: ;
            endcase
        end
    end

    // Bit counter, input shifter and command latch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_sr   <= '0;
            r_rw   <= 1'b0;
            r_addr <= '0;
        end else begin
            if (w_clr) begin
                r_cnt <= '0;
                r_sr  <= '0;
            end else if (w_shift_in) begin
                r_cnt <= r_cnt + CNT_W'(1);
                r_sr  <= {r_sr[5:0], bus.spi_mosi};
            end
            if (w_latch_cmd) begin
                r_rw   <= r_sr[6];
                r_addr <= {r_sr[5:0], bus.spi_mosi};
            end
        end
    end

    // Register bank write commit on the 16th rise of an in-range write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_REGS; k++) r_regs[k] <= '0;
            r_wr_strobe <= 1'b0;
            r_wr_addr   <= '0;
        end else begin
            r_wr_strobe <= w_commit;
            if (w_commit) begin
                r_wr_addr <= r_addr;
                for (int k = 0; k < NUM_REGS; k++) begin
                    if (r_addr == 7'(k)) r_regs[k] <= REG_WIDTH'({r_sr, bus.spi_mosi});
                end
            end
        end
    end

`ifdef SPI_READBACK_EN
    // Read mux; out-of-range addresses read back as zero
    always_comb begin
        w_rd_data = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (r_addr == 7'(k)) w_rd_data = r_regs[k];
        end
    end

    // Output shifter next value: load at CMD->DATA, shift left on each DATA fall
    always_comb begin
        w_out_nx = r_out;
        if (w_clr)            w_out_nx = '0;
        else if (w_load_out)  w_out_nx = r_rw ? '0 : w_rd_data;
        else if (w_shift_out) w_out_nx = {r_out[REG_WIDTH-2:0], 1'b0};
    end

    // Output shifter and registered MISO, driven only in DATA with cs low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out  <= '0;
            r_miso <= 1'b0;
        end else begin
            r_out  <= w_out_nx;
            r_miso <= (w_state_nx == S_DATA) && !bus.spi_cs_n && w_out_nx[REG_WIDTH-1];
        end
    end

    assign bus.spi_miso = r_miso;
`else
    assign bus.spi_miso = 1'b0;
`endif

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs_out
        assign bus.regs[k*REG_WIDTH +: REG_WIDTH] = r_regs[k];
    end

    assign bus.wr_strobe = r_wr_strobe;
    assign bus.wr_addr   = r_wr_addr;

endmodule

// File: tb/tb_spi_reg_bank.sv
// tb_spi_reg_bank: directed plus random SPI frames against a frame-level register model.
module tb_spi_reg_bank;

    localparam int unsigned NUM_REGS = 4;
    localparam int unsigned RWID     = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_reg_bank_if #(.NUM_REGS(NUM_REGS), .REG_WIDTH(RWID)) bus ();

    spi_reg_bank #(.NUM_REGS(NUM_REGS), .REG_WIDTH(RWID)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         n_cmp = 0;
    int         n_err = 0;
    int         strobe_cnt;
    int         miso_seen;
    logic [7:0] m_regs [NUM_REGS];
    logic [6:0] m_wr_addr;
    logic [7:0] rx;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_flat();
        logic [31:0] v;
        v = '0;
        for (int k = 0; k < int'(NUM_REGS); k++) v[k*8 +: 8] = m_regs[k];
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < int'(NUM_REGS); k++) m_regs[k] = 8'h00;
        m_wr_addr = 7'd0;
    endtask

    // Frame-level effect: only a complete 16-rise frame has any effect
    task automatic model_frame(input logic [15:0] f, input int n,
                               output logic [7:0] exp_rx, output int exp_strobes);
        int a;
        a           = int'(f[14:8]);
        exp_rx      = 8'h00;
        exp_strobes = 0;
        if (n == 16) begin
            if (f[15]) begin
                if (a < int'(NUM_REGS)) begin
                    m_regs[a]   = f[7:0];
                    m_wr_addr   = f[14:8];
                    exp_strobes = 1;
                end
            end else begin
`ifdef SPI_READBACK_EN
                if (a < int'(NUM_REGS)) exp_rx = m_regs[a];
`endif
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        strobe_cnt += int'(bus.wr_strobe);
        if (bus.spi_miso === 1'b1) miso_seen = 1;
    endtask

    // Mode-0 master: cs low, then n bits with 4-clk phases; MISO sampled just before each rise
    task automatic drive_bits(input logic [15:0] f, input int n);
        bus.spi_cs_n = 1'b0;
        repeat (4) tick();
        rx = 8'h00;
        for (int i = 0; i < n; i++) begin
            bus.spi_mosi = f[15-i];
            repeat (4) tick();
            if (i >= 8) rx[15-i] = bus.spi_miso;
            bus.spi_sclk = 1'b1;
            repeat (4) tick();
            bus.spi_sclk = 1'b0;
        end
        repeat (4) tick();
    endtask

    task automatic cs_up();
        bus.spi_cs_n = 1'b1;
        repeat (4) tick();
    endtask

    task automatic do_frame(input string tag, input logic [15:0] f, input int n);
        logic [7:0] erx;
        int         es;
        strobe_cnt = 0;
        miso_seen  = 0;
        drive_bits(f, n);
        cs_up();
        model_frame(f, n, erx, es);
        check({tag, ".regs"},    bus.regs, model_flat());
        check({tag, ".wr_addr"}, 32'(bus.wr_addr), 32'(m_wr_addr));
        check({tag, ".strobes"}, 32'(strobe_cnt), 32'(es));
        if (n == 16 && !f[15]) check({tag, ".rx"}, 32'(rx), 32'(erx));
`ifdef SPI_READBACK_EN
        if (f[15]) check({tag, ".miso_quiet"}, 32'(miso_seen), 32'd0);
`else
        check({tag, ".miso_quiet"}, 32'(miso_seen), 32'd0);
`endif
    endtask

    initial begin
        logic [15:0] f;
        int          n;
        logic [6:0]  a;

        rst          = 1'b1;
        bus.ena      = 1'b1;
        bus.spi_cs_n = 1'b1;
        bus.spi_sclk = 1'b0;
        bus.spi_mosi = 1'b0;
        strobe_cnt   = 0;
        miso_seen    = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset.regs",      bus.regs, 32'h0);
        check("reset.miso",      32'(bus.spi_miso), 32'd0);
        check("reset.wr_strobe", 32'(bus.wr_strobe), 32'd0);
        check("reset.wr_addr",   32'(bus.wr_addr), 32'd0);
        rst = 1'b0;
        repeat (4) tick();

        do_frame("wr_82A5", 16'h82A5, 16);
        check("wr_82A5.byte2", 32'(bus.regs[23:16]), 32'hA5);
        do_frame("rd_0200", 16'h0200, 16);
        do_frame("oor_8933", 16'h8933, 16);
        do_frame("abort_8177", 16'h8177, 12);
        do_frame("after_abort_rd", 16'h0100, 16);

        // Boundary: cs release detected in the same cycle as the 16th rise
        strobe_cnt = 0;
        drive_bits(16'h8155, 15);
        bus.spi_mosi = 1'b1;
        repeat (4) tick();
        bus.spi_sclk = 1'b1;
        bus.spi_cs_n = 1'b1;
        repeat (4) tick();
        bus.spi_sclk = 1'b0;
        repeat (4) tick();
        check("cs_vs_16th.regs",    bus.regs, model_flat());
        check("cs_vs_16th.strobes", 32'(strobe_cnt), 32'd0);

        // Enable drop mid-frame, then a clean frame
        strobe_cnt = 0;
        drive_bits(16'h80FF, 10);
        bus.ena = 1'b0;
        repeat (3) tick();
        cs_up();
        bus.ena = 1'b1;
        repeat (2) tick();
        check("ena_drop.regs",    bus.regs, model_flat());
        check("ena_drop.strobes", 32'(strobe_cnt), 32'd0);
        do_frame("ena_resume", 16'h8011, 16);
        check("ena_resume.byte0", 32'(bus.regs[7:0]), 32'h11);

        // Async reset mid-DATA of a read of reg 0 (0x11): bit 4 is on MISO
        miso_seen = 0;
        drive_bits(16'h0000, 11);
`ifdef SPI_READBACK_EN
        check("pre_rst.miso", 32'(bus.spi_miso), 32'd1);
`else
        check("pre_rst.miso", 32'(bus.spi_miso), 32'd0);
`endif
        rst = 1'b1;
        #1;
        model_reset();
        check("mid_rst.regs",      bus.regs, 32'h0);
        check("mid_rst.miso",      32'(bus.spi_miso), 32'd0);
        check("mid_rst.wr_strobe", 32'(bus.wr_strobe), 32'd0);
        check("mid_rst.wr_addr",   32'(bus.wr_addr), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cs_up();
        do_frame("post_rst_8322", 16'h8322, 16);
        check("post_rst.byte3", 32'(bus.regs[31:24]), 32'h22);

        // Randomized frames: mixed reads/writes, out-of-range addresses, truncated frames
        for (int t = 0; t < 30; t++) begin
            a = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(4, 127)) : 7'($urandom_range(0, 5));
            f = {1'($urandom_range(0, 1)), a, 8'($urandom)};
            n = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 15)) : 16;
            do_frame($sformatf("rnd%0d_%04h_n%0d", t, f, n), f, n);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
